// File: rtl/btb_pkg.sv
// Shared types for the set-associative branch target buffer: counter
// encodings, flush FSM states, the stored entry layout and counter update.
package btb_pkg;

    // Storage widths for the entry fields. Narrower configurations zero-extend
    // into these, and the constant upper bits are optimised away.
    localparam int unsigned BTB_MAX_ADDR_W = 64;
    localparam int unsigned BTB_MAX_TAG_W  = 64;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    typedef struct packed {
        logic                      valid;
        logic [BTB_MAX_TAG_W-1:0]  tag;
        logic [BTB_MAX_ADDR_W-1:0] target;
        ctr_t                      ctr;
    } btb_entry_t;

    // Next state of the 2-bit hysteresis counter after a resolved outcome.
    function automatic ctr_t ctr_next(input ctr_t cur, input logic taken, input logic is_jump);
        ctr_t nxt;
        nxt = cur;
        if (is_jump) begin
            nxt = ST;
        end else if (taken) begin
            if (cur != ST) nxt = ctr_t'(cur + 2'd1);
        end else begin
            if (cur != SNT) nxt = ctr_t'(cur - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/btb_set.sv
// One set of the BTB: WAYS entries, tag compare for lookup and update,
// hit-way select, allocate with round-robin victim, and whole-set clear.
module btb_set
    import btb_pkg::*;
#(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned WAYS   = 2,
    parameter int unsigned TAG_W  = 59
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [TAG_W-1:0]  lookup_tag,
    output logic              hit,
    output logic [ADDR_W-1:0] hit_target,
    output ctr_t              hit_ctr,
    input  logic              upd_en,
    input  logic [TAG_W-1:0]  upd_tag,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_taken,
    input  logic              upd_is_jump
);

    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    btb_entry_t                entries_reg [WAYS];
    logic [WAY_W-1:0]          ptr_reg;
    logic [BTB_MAX_TAG_W-1:0]  lookup_tag_ext;
    logic [BTB_MAX_TAG_W-1:0]  upd_tag_ext;
    logic [BTB_MAX_ADDR_W-1:0] upd_target_ext;
    logic [WAYS-1:0]           way_valid;
    logic [WAYS-1:0]           lookup_match;
    logic [WAYS-1:0]           upd_match;
    logic                      upd_hit;
    logic [WAY_W-1:0]          upd_way;
    logic [WAY_W-1:0]          victim_way;
    logic                      set_full;
    logic                      upd_alloc;

    // Widen the incoming tag and target to the stored field widths.
    always_comb begin
        lookup_tag_ext                 = '0;
        lookup_tag_ext[TAG_W-1:0]      = lookup_tag;
        upd_tag_ext                    = '0;
        upd_tag_ext[TAG_W-1:0]         = upd_tag;
        upd_target_ext                 = '0;
        upd_target_ext[ADDR_W-1:0]     = upd_target;
    end

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            assign way_valid[gi]    = entries_reg[gi].valid;
            assign lookup_match[gi] = entries_reg[gi].valid && (entries_reg[gi].tag == lookup_tag_ext);
            assign upd_match[gi]    = entries_reg[gi].valid && (entries_reg[gi].tag == upd_tag_ext);
        end
    endgenerate

    // Lookup side: tags are unique per set, so at most one way matches.
    always_comb begin
        hit        = |lookup_match;
        hit_target = '0;
        hit_ctr    = SNT;
        for (int w = 0; w < WAYS; w++) begin
            if (lookup_match[w]) begin
                hit_target = entries_reg[w].target[ADDR_W-1:0];
                hit_ctr    = entries_reg[w].ctr;
            end
        end
    end

    // Update side: matching way, and the victim (lowest invalid, else pointer).
    always_comb begin
        upd_hit    = |upd_match;
        upd_way    = '0;
        set_full   = &way_valid;
        victim_way = ptr_reg;
        for (int w = 0; w < WAYS; w++) begin
            if (upd_match[w]) upd_way = WAY_W'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) victim_way = WAY_W'(w);
        end
    end

    assign upd_alloc = upd_en && !upd_hit && (upd_taken || upd_is_jump);

    // Round-robin pointer only exists with more than one way; it moves only
    // when a valid entry is evicted.
    generate
        if (WAYS > 1) begin : g_ptr
            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    ptr_reg <= '0;
                end else if (upd_alloc && set_full) begin
                    ptr_reg <= ptr_reg + 1'b1;
                end
            end
        end else begin : g_no_ptr
            assign ptr_reg = '0;
        end
    endgenerate

    // Entry storage: reset/clear invalidate, hits retrain, taken misses allocate.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++) begin
                entries_reg[w].valid <= 1'b0;
                entries_reg[w].ctr   <= SNT;
            end
        end else if (clear) begin
            for (int w = 0; w < WAYS; w++) begin
                entries_reg[w].valid <= 1'b0;
            end
        end else if (upd_en) begin
            if (upd_hit) begin
                entries_reg[upd_way].ctr <= ctr_next(entries_reg[upd_way].ctr, upd_taken, upd_is_jump);
                if (upd_taken || upd_is_jump) begin
                    entries_reg[upd_way].target <= upd_target_ext;
                end
            end else if (upd_alloc) begin
                entries_reg[victim_way] <= '{valid:  1'b1,
                                             tag:    upd_tag_ext,
                                             target: upd_target_ext,
                                             ctr:    (upd_is_jump ? ST : WT)};
            end
        end
    end

endmodule

// File: rtl/branch_target_buffer_sa.sv
// Set-associative branch target buffer: index decode, per-set storage,
// registered prediction and a one-set-per-cycle flush sequencer.
module branch_target_buffer_sa
    import btb_pkg::*;
#(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned SETS   = 8,
    parameter int unsigned WAYS   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_taken,
    input  logic              upd_is_jump,
    input  logic              flush,
    output logic              busy
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR_W - 2 - IDX_W;

    state_t            state_reg;
    logic [IDX_W-1:0]  cnt_reg;
    logic              pred_valid_reg;
    logic              pred_taken_reg;
    logic [ADDR_W-1:0] pred_target_reg;

    logic [IDX_W-1:0]  lookup_idx;
    logic [TAG_W-1:0]  lookup_tag;
    logic [IDX_W-1:0]  upd_idx;
    logic [TAG_W-1:0]  upd_tag;
    logic              upd_accept;
    logic              unused_low_bits;

    logic              set_hit    [SETS];
    logic [ADDR_W-1:0] set_target [SETS];
    ctr_t              set_ctr    [SETS];
    logic [SETS-1:0]   set_clear;
    logic [SETS-1:0]   set_upd;
    ctr_t              lookup_ctr;

    assign lookup_idx      = lookup_pc[IDX_W+1:2];
    assign lookup_tag      = lookup_pc[ADDR_W-1:IDX_W+2];
    assign upd_idx         = upd_pc[IDX_W+1:2];
    assign upd_tag         = upd_pc[ADDR_W-1:IDX_W+2];
    assign unused_low_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign busy = (state_reg == FLUSH);

    // A same-cycle flush request takes priority over an update.
    assign upd_accept = en && upd_valid && !busy && !flush;

    genvar gi;
    generate
        for (gi = 0; gi < SETS; gi++) begin : g_set
            assign set_clear[gi] = busy && (cnt_reg == IDX_W'(gi));
            assign set_upd[gi]   = upd_accept && (upd_idx == IDX_W'(gi));

            btb_set #(
                .ADDR_W (ADDR_W),
                .WAYS   (WAYS),
                .TAG_W  (TAG_W)
            ) u_set (
                .clk         (clk),
                .rst         (rst),
                .clear       (set_clear[gi]),
                .lookup_tag  (lookup_tag),
                .hit         (set_hit[gi]),
                .hit_target  (set_target[gi]),
                .hit_ctr     (set_ctr[gi]),
                .upd_en      (set_upd[gi]),
                .upd_tag     (upd_tag),
                .upd_target  (upd_target),
                .upd_taken   (upd_taken),
                .upd_is_jump (upd_is_jump)
            );
        end
    endgenerate

    assign lookup_ctr = set_ctr[lookup_idx];

    // Prediction register: sees pre-update table contents, forced to miss while flushing.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid_reg  <= 1'b0;
            pred_taken_reg  <= 1'b0;
            pred_target_reg <= '0;
        end else if (en) begin
            if (busy || !set_hit[lookup_idx]) begin
                pred_valid_reg  <= 1'b0;
                pred_taken_reg  <= 1'b0;
                pred_target_reg <= '0;
            end else begin
                pred_valid_reg  <= 1'b1;
                pred_taken_reg  <= lookup_ctr[1];
                pred_target_reg <= set_target[lookup_idx];
            end
        end
    end

    assign pred_valid  = pred_valid_reg;
    assign pred_taken  = pred_taken_reg;
    assign pred_target = pred_target_reg;

    // Flush sequencer: clears set cnt each cycle, independent of en.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (flush) begin
                        state_reg <= FLUSH;
                        cnt_reg   <= '0;
                    end
                end
                FLUSH: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == IDX_W'(SETS - 1)) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_target_buffer_sa.sv
// Bench for branch_target_buffer_sa (SETS=8, WAYS=2, ADDR_W=64): a vector
// table of directed cycles, hand sequences for flush and mid-flush reset,
// then random traffic compared against a behavioural model.
module tb_branch_target_buffer_sa;

    logic        clk = 1'b0;
    logic        rst, en, upd_valid, upd_taken, upd_is_jump, flush;
    logic [63:0] lookup_pc, upd_pc, upd_target;
    logic        pred_valid, pred_taken, busy;
    logic [63:0] pred_target;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    branch_target_buffer_sa #(.ADDR_W(64), .SETS(8), .WAYS(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .lookup_pc   (lookup_pc),
        .pred_valid  (pred_valid),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_target  (upd_target),
        .upd_taken   (upd_taken),
        .upd_is_jump (upd_is_jump),
        .flush       (flush),
        .busy        (busy)
    );

    typedef struct {
        bit          rst;
        bit          en;
        logic [63:0] lpc;
        bit          uv;
        logic [63:0] upc;
        logic [63:0] utgt;
        bit          ut;
        bit          uj;
        bit          fl;
        bit          ev;
        bit          et;
        logic [63:0] etgt;
        bit          eb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit e, logic [63:0] lpc, bit uv, logic [63:0] upc,
                                logic [63:0] utgt, bit ut, bit uj, bit fl,
                                bit ev, bit et, logic [63:0] etgt, bit eb);
        vec_t v;
        v.rst = r; v.en = e; v.lpc = lpc; v.uv = uv; v.upc = upc; v.utgt = utgt;
        v.ut = ut; v.uj = uj; v.fl = fl; v.ev = ev; v.et = et; v.etgt = etgt; v.eb = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc %0d rst=%0b en=%0b lpc=%h upd=%0b/%h t=%0b j=%0b fl=%0b -> pv=%0b pt=%0b tgt=%h busy=%0b",
                 cyc, rst, en, lookup_pc, upd_valid, upd_pc, upd_taken, upd_is_jump, flush,
                 pred_valid, pred_taken, pred_target, busy);
    endtask

    task automatic idle_inputs(input logic [63:0] lpc);
        rst = 1'b0; en = 1'b1; lookup_pc = lpc; upd_valid = 1'b0; upd_pc = '0;
        upd_target = '0; upd_taken = 1'b0; upd_is_jump = 1'b0; flush = 1'b0;
    endtask

    // ---------------- behavioural model ----------------
    bit          mv   [8][2];
    logic [63:0] mtag [8][2];
    logic [63:0] mtgt [8][2];
    int          mctr [8][2];
    int          mptr [8];
    bit          mbusy;
    int          mcnt;
    bit          ev, et;
    logic [63:0] etgt;

    task automatic model_step();
        int s, hw, vw;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                mptr[i] = 0;
                for (int w = 0; w < 2; w++) begin mv[i][w] = 0; mctr[i][w] = 0; end
            end
            ev = 0; et = 0; etgt = 0; mbusy = 0; mcnt = 0;
            return;
        end
        if (en) begin
            ev = 0; et = 0; etgt = 0;
            if (!mbusy) begin
                s = int'((lookup_pc / 4) % 8);
                for (int w = 0; w < 2; w++)
                    if (mv[s][w] && mtag[s][w] == lookup_pc / 32) begin
                        ev = 1; et = (mctr[s][w] >= 2); etgt = mtgt[s][w];
                    end
            end
        end
        if (mbusy) begin
            mv[mcnt][0] = 0; mv[mcnt][1] = 0; mptr[mcnt] = 0;
            mcnt++;
            if (mcnt == 8) mbusy = 0;
        end else if (flush) begin
            mbusy = 1; mcnt = 0;
        end else if (en && upd_valid) begin
            s = int'((upd_pc / 4) % 8);
            hw = -1;
            for (int w = 0; w < 2; w++)
                if (mv[s][w] && mtag[s][w] == upd_pc / 32) hw = w;
            if (hw >= 0) begin
                if (upd_is_jump) begin mctr[s][hw] = 3; mtgt[s][hw] = upd_target; end
                else if (upd_taken) begin
                    mctr[s][hw] = (mctr[s][hw] < 3) ? mctr[s][hw] + 1 : 3; mtgt[s][hw] = upd_target;
                end else mctr[s][hw] = (mctr[s][hw] > 0) ? mctr[s][hw] - 1 : 0;
            end else if (upd_taken || upd_is_jump) begin
                vw = -1;
                for (int w = 0; w < 2; w++) if (!mv[s][w] && vw < 0) vw = w;
                if (vw < 0) begin vw = mptr[s]; mptr[s] = (mptr[s] + 1) % 2; end
                mv[s][vw] = 1; mtag[s][vw] = upd_pc / 32; mtgt[s][vw] = upd_target;
                mctr[s][vw] = upd_is_jump ? 3 : 2;
            end
        end
    endtask

    function automatic logic [63:0] rand_pc();
        logic [63:0] hi;
        hi = ($urandom_range(0, 1) != 0) ? 64'hA5A5_0000_0000_0000 : 64'h0;
        return hi + 64'h10000 + 64'($urandom_range(0, 2)) * 32 + 64'($urandom_range(0, 7)) * 4
               + 64'($urandom_range(0, 3));
    endfunction

    task automatic fill_all();
        for (int s = 0; s < 8; s++) begin
            idle_inputs(64'h100);
            upd_valid = 1'b1; upd_pc = 64'h8000 + 64'(s) * 4;
            upd_target = 64'h9000 + 64'(s) * 4; upd_taken = 1'b1;
            tick();
        end
        idle_inputs(64'h100);
    endtask

    int busy_cnt;
    int guard;

    initial begin
        idle_inputs(64'h0);
        rst = 1'b1;

        // Directed vector table (index = pc[4:2]; all 0x?004 PCs share set 1).
        vecs.push_back(mk(1,0,64'h0,   0,64'h0,   64'h0,   0,0,0, 0,0,64'h0,   0));
        vecs.push_back(mk(0,1,64'h1000,0,64'h0,   64'h0,   0,0,0, 0,0,64'h0,   0));
        vecs.push_back(mk(0,1,64'h1004,1,64'h1004,64'h2000,1,0,0, 0,0,64'h0,   0));
        vecs.push_back(mk(0,1,64'h1004,0,64'h0,   64'h0,   0,0,0, 1,1,64'h2000,0));
        vecs.push_back(mk(0,1,64'h1004,1,64'h1004,64'h7777,0,0,0, 1,1,64'h2000,0));
        vecs.push_back(mk(0,1,64'h1004,1,64'h1004,64'h7777,0,0,0, 1,0,64'h2000,0));
        vecs.push_back(mk(0,1,64'h1004,0,64'h0,   64'h0,   0,0,0, 1,0,64'h2000,0));
        vecs.push_back(mk(0,1,64'h1004,1,64'h1004,64'h2400,0,1,0, 1,0,64'h2000,0));
        vecs.push_back(mk(0,1,64'h1004,0,64'h0,   64'h0,   0,0,0, 1,1,64'h2400,0));
        vecs.push_back(mk(0,1,64'h1004,1,64'h1004,64'h9990,0,0,0, 1,1,64'h2400,0));
        vecs.push_back(mk(0,1,64'h1004,0,64'h0,   64'h0,   0,0,0, 1,1,64'h2400,0));
        vecs.push_back(mk(0,1,64'h1000,1,64'h2004,64'h2100,1,0,0, 0,0,64'h0,   0));
        vecs.push_back(mk(0,1,64'h1000,1,64'h3004,64'h3100,1,0,0, 0,0,64'h0,   0));
        vecs.push_back(mk(0,1,64'h1004,0,64'h0,   64'h0,   0,0,0, 0,0,64'h0,   0));
        vecs.push_back(mk(0,1,64'h2004,0,64'h0,   64'h0,   0,0,0, 1,1,64'h2100,0));
        vecs.push_back(mk(0,1,64'h3004,0,64'h0,   64'h0,   0,0,0, 1,1,64'h3100,0));
        vecs.push_back(mk(0,1,64'h3004,1,64'h4004,64'h4100,1,0,0, 1,1,64'h3100,0));
        vecs.push_back(mk(0,1,64'h2004,0,64'h0,   64'h0,   0,0,0, 0,0,64'h0,   0));
        vecs.push_back(mk(0,1,64'h4004,0,64'h0,   64'h0,   0,0,0, 1,1,64'h4100,0));
        vecs.push_back(mk(0,0,64'h1000,1,64'h1004,64'h5000,1,0,0, 1,1,64'h4100,0));
        vecs.push_back(mk(0,1,64'h1004,0,64'h0,   64'h0,   0,0,0, 0,0,64'h0,   0));
        vecs.push_back(mk(0,1,64'h3004,1,64'h5004,64'h5100,0,0,0, 1,1,64'h3100,0));
        vecs.push_back(mk(0,1,64'h5004,0,64'h0,   64'h0,   0,0,0, 0,0,64'h0,   0));
        vecs.push_back(mk(0,1,64'h3007,0,64'h0,   64'h0,   0,0,0, 1,1,64'h3100,0));
        vecs.push_back(mk(0,1,64'h3004,1,64'h3004,64'h3200,1,0,0, 1,1,64'h3100,0));
        vecs.push_back(mk(0,1,64'h3004,1,64'h3004,64'h0,   0,0,0, 1,1,64'h3200,0));
        vecs.push_back(mk(0,1,64'h3004,1,64'h3004,64'h0,   0,0,0, 1,1,64'h3200,0));
        vecs.push_back(mk(0,1,64'h3004,0,64'h0,   64'h0,   0,0,0, 1,0,64'h3200,0));
        vecs.push_back(mk(0,1,64'h1000,1,64'h6004,64'h6100,1,0,1, 0,0,64'h0,   1));
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(0,1,64'h4004,0,64'h0,64'h0,0,0,0, 0,0,64'h0,1));
        vecs.push_back(mk(0,1,64'h4004,0,64'h0,   64'h0,   0,0,0, 0,0,64'h0,   0));
        vecs.push_back(mk(0,1,64'h6004,0,64'h0,   64'h0,   0,0,0, 0,0,64'h0,   0));
        vecs.push_back(mk(0,1,64'h4004,0,64'h0,   64'h0,   0,0,0, 0,0,64'h0,   0));
        vecs.push_back(mk(0,1,64'h3004,0,64'h0,   64'h0,   0,0,0, 0,0,64'h0,   0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; en = vecs[i].en; lookup_pc = vecs[i].lpc;
            upd_valid = vecs[i].uv; upd_pc = vecs[i].upc; upd_target = vecs[i].utgt;
            upd_taken = vecs[i].ut; upd_is_jump = vecs[i].uj; flush = vecs[i].fl;
            tick();
            check($sformatf("vec%0d pred_valid", i), 64'(pred_valid), 64'(vecs[i].ev));
            check($sformatf("vec%0d pred_taken", i), 64'(pred_taken), 64'(vecs[i].et));
            check($sformatf("vec%0d pred_target", i), pred_target, vecs[i].etgt);
            check($sformatf("vec%0d busy", i), 64'(busy), 64'(vecs[i].eb));
        end

        // Fill every set, confirm hits, then flush with an update during busy.
        fill_all();
        for (int s = 0; s < 8; s++) begin
            idle_inputs(64'h8000 + 64'(s) * 4);
            tick();
            check($sformatf("fill_hit set%0d", s), 64'(pred_valid), 64'd1);
            check($sformatf("fill_tgt set%0d", s), pred_target, 64'h9000 + 64'(s) * 4);
        end
        idle_inputs(64'h100);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        busy_cnt = 0;
        guard = 0;
        while (busy === 1'b1 && guard < 20) begin
            busy_cnt++;
            check($sformatf("flush_busy_miss c%0d", busy_cnt), 64'(pred_valid), 64'd0);
            idle_inputs(64'h8000 + 64'(busy_cnt % 8) * 4);
            if (busy_cnt == 3) begin
                upd_valid = 1'b1; upd_pc = 64'hA004; upd_target = 64'hB000; upd_taken = 1'b1;
            end
            tick();
            guard++;
        end
        check("flush_busy_cycles", 64'(busy_cnt), 64'd8);
        check("flush_last_miss", 64'(pred_valid), 64'd0);
        for (int s = 0; s < 9; s++) begin
            idle_inputs((s == 8) ? 64'hA004 : 64'h8000 + 64'(s) * 4);
            tick();
            check($sformatf("after_flush_miss %0d", s), 64'(pred_valid), 64'd0);
        end

        // Reset in the 3rd busy cycle aborts the flush and clears everything.
        fill_all();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("midrst busy1", 64'(busy), 64'd1);
        tick();
        check("midrst busy2", 64'(busy), 64'd1);
        tick();
        check("midrst busy3", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst busy_after", 64'(busy), 64'd0);
        check("midrst pred_valid", 64'(pred_valid), 64'd0);
        check("midrst pred_taken", 64'(pred_taken), 64'd0);
        check("midrst pred_target", pred_target, 64'd0);
        for (int s = 0; s < 8; s++) begin
            idle_inputs(64'h8000 + 64'(s) * 4);
            tick();
            check($sformatf("midrst_miss set%0d", s), 64'(pred_valid), 64'd0);
        end
        idle_inputs(64'h100);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        busy_cnt = 0;
        guard = 0;
        while (busy === 1'b1 && guard < 20) begin
            busy_cnt++;
            tick();
            guard++;
        end
        check("reflush_busy_cycles", 64'(busy_cnt), 64'd8);

        // Random traffic against the behavioural model.
        idle_inputs(64'h0);
        rst = 1'b1;
        model_step();
        tick();
        for (int i = 0; i < 800; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            en          = ($urandom_range(0, 9) != 0);
            lookup_pc   = rand_pc();
            upd_valid   = ($urandom_range(0, 1) != 0);
            upd_pc      = rand_pc();
            upd_target  = {$urandom, $urandom};
            upd_taken   = ($urandom_range(0, 2) != 0);
            upd_is_jump = ($urandom_range(0, 5) == 0);
            flush       = ($urandom_range(0, 59) == 0);
            model_step();
            tick();
            check($sformatf("rand%0d pred_valid", i), 64'(pred_valid), 64'(ev));
            check($sformatf("rand%0d pred_taken", i), 64'(pred_taken), 64'(et));
            check($sformatf("rand%0d pred_target", i), pred_target, etgt);
            check($sformatf("rand%0d busy", i), 64'(busy), 64'(mbusy));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer_sa.md
# branch_target_buffer_sa

Parametrised set-associative branch target buffer for the fetch stage. It replaces the direct-mapped, 8-row, tag-equals-full-PC buffer with configurable sets and ways, and stores a partial tag, a 2-bit taken/not-taken hysteresis counter and round-robin replacement per set. A multi-cycle flush sequence invalidates the whole table. Fetch presents a lookup PC each cycle, and the resolve stage returns branch and jump outcomes through a single update port.

## Interface
- ADDR_W, 64, PC width in bits.
- SETS, 8, number of sets; must be a power of 2 and at least 2; IDX_W = log2(SETS).
- WAYS, 2, associativity; must be 1, 2 or 4.
- TAG_W, ADDR_W-2-IDX_W, derived localparam, not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  stage enable; gates lookup register load and updates.
- lookup_pc  in  ADDR_W  fetch PC to predict.
- pred_valid  out  1  registered hit flag.
- pred_taken  out  1  registered direction (counter MSB).
- pred_target  out  ADDR_W  registered target; 0 on miss.
- upd_valid  in  1  update strobe from resolve.
- upd_pc  in  ADDR_W  PC of the resolved control instruction.
- upd_target  in  ADDR_W  resolved target.
- upd_taken  in  1  branch resolved as taken.
- upd_is_jump  in  1  unconditional jump; implies taken.
- flush  in  1  single-cycle request to invalidate all entries.
- busy  out  1  flush in progress.

## Operation
- Address split: index = pc[IDX_W+1:2], tag = pc[ADDR_W-1:IDX_W+2]. The low 2 bits are ignored.
- Entry fields: valid, tag[TAG_W], target[ADDR_W], ctr[2] encoded as SNT=0, WNT=1, WT=2, ST=3.
- Per-set state: a round-robin victim pointer of log2(WAYS) bits. When WAYS=1 there is no pointer.
- Lookup:
  - A hit means some way in the indexed set is valid with a matching tag.
  - On a hit: pred_valid=1, pred_taken=ctr[1], pred_target=target.
  - On a miss: all three outputs are 0.
  - Tags are unique within a set, so at most one way can hit.
- Update on a hit:
  - upd_is_jump: ctr=ST and target is overwritten.
  - upd_taken: ctr is saturating-incremented and target is overwritten.
  - Otherwise: ctr is saturating-decremented and target is kept.
- Update on a miss:
  - If taken or jump, allocate. The victim is the lowest-index invalid way; if no way is invalid, the victim is the way under the pointer.
  - A new entry gets ctr=WT, or ST for a jump.
  - The pointer advances (mod WAYS) only when a valid entry is evicted.
  - A not-taken miss changes nothing.
- FSM has two states, IDLE and FLUSH.
  - IDLE to FLUSH happens when flush=1. The flush counter is set to 0.
  - In FLUSH, each cycle clears the valid bits and the pointer of set[cnt], then increments cnt.
  - FLUSH to IDLE happens after set SETS-1 is cleared.
  - flush is ignored while in FLUSH.
- While busy:
  - Lookups register a miss.
  - upd_valid is ignored.
  - The flush sequence advances regardless of en.
- en=0: prediction outputs hold their values and updates are dropped.
- Lookup and update in the same cycle: the lookup sees pre-update table contents. There is no bypass.
- flush and upd_valid in the same cycle while IDLE: flush wins and the update is dropped.
- rst: in one cycle, clears every valid bit, counter, pointer and pred_* output, sets busy=0 and returns the FSM to IDLE. rst overrides flush, en and any update, including mid-flush.

## Timing
- Lookup latency is 1 cycle. lookup_pc sampled at edge N appears on pred_* after edge N.
- An update sampled at edge N is visible to a lookup sampled at edge N+1.
- flush sampled at edge E: busy=1 after E, set k is cleared at edge E+1+k, and busy=0 after edge E+SETS. busy is high for exactly SETS cycles.
- Reset values: pred_valid=0, pred_taken=0, pred_target=0, busy=0.

## Structure
- Package btb_pkg holds:
  - the counter encodings SNT/WNT/WT/ST;
  - the FSM state enum (IDLE, FLUSH);
  - the entry struct (valid, tag, target, ctr);
  - a function computing the saturating counter's next value.
- Sub-module btb_set holds one set's WAYS entries plus its victim pointer. It provides tag compare, hit-way select, update/allocate and clear.
- The top level instantiates SETS copies of btb_set and contains the index decode, output register, flush FSM and counter.

## Test plan
Configuration: SETS=8, WAYS=2, ADDR_W=64, so index = pc[4:2].
- Reset, then lookup 0x1000 -> pred_valid=0, pred_taken=0, pred_target=0, busy=0.
- Update pc 0x1004 taken with target 0x2000, then lookup 0x1004 -> next cycle pred_valid=1, pred_taken=1, pred_target=0x2000. Lookup 0x1004 in the same cycle as the update -> miss.
- Two not-taken updates at 0x1004 -> ctr goes 2→1→0. Lookup gives pred_valid=1, pred_taken=0, pred_target still 0x2000. A jump update then gives ctr=3 and pred_taken=1.
- Taken updates at 0x1004, 0x2004, then 0x3004 (all index 1) -> 0x3004 evicts 0x1004 (way 0). Lookup 0x1004 misses, 0x2004 and 0x3004 hit. A further 0x4004 evicts 0x2004.
- Fill all sets, then pulse flush -> busy high for exactly 8 cycles. An upd_valid during busy is dropped. Lookups during and after busy all miss.
- Assert rst on the 3rd busy cycle -> busy=0 and pred_*=0 after that edge, and all entries read invalid. A subsequent flush runs the full 8 cycles.
